// File: rtl/xbar_controller_port.sv
// Controller-side crossbar stage: decodes a word address into one of three
// peripheral regions, drives the matching request and returns a one-cycle response.
module xbar_controller_port #(
    parameter int WORD_ADDR_WIDTH = 16,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       c_req_i,
    input  logic [WORD_ADDR_WIDTH-1:0] c_addr_i,
    input  logic                       c_wen_i,
    input  logic [31:0]                c_wdata_i,
    input  logic [3:0]                 c_be_i,
    output logic                       c_gnt_o,
    output logic                       c_rvalid_o,
    output logic [31:0]                c_rdata_o,
    output logic                       c_err_o,
    output logic [2:0]                 p_matching_req_o,
    input  logic [2:0]                 p_ready_and_selected_i,
    input  logic [95:0]                p_rdata_i,
    input  logic                       stall_clr_i,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t                     state_q;
    logic [1:0]                 region;
    logic                       unmapped;
    logic                       sel_ready;
    logic                       rsp_valid_q;
    logic [1:0]                 rsp_sel_q;
    logic                       rsp_read_q;
    logic                       rsp_err_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

    // Write data, byte enables and the low address bits are consumed by the
    // peripheral ports, not by this stage.
    logic unused_passthrough;
    assign unused_passthrough = ^{c_wdata_i, c_be_i, c_addr_i[WORD_ADDR_WIDTH-3:0]};

    assign region   = c_addr_i[WORD_ADDR_WIDTH-1 -: 2];
    assign unmapped = (region == 2'b11);

    // NOTE: every output of an always_comb gets a default first so that no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        p_matching_req_o = 3'b000;
        sel_ready        = 1'b0;
        case (region)
            2'd0: begin
                p_matching_req_o[0] = c_req_i & ~rst_i;
                sel_ready           = p_ready_and_selected_i[0];
            end
            2'd1: begin
                p_matching_req_o[1] = c_req_i & ~rst_i;
                sel_ready           = p_ready_and_selected_i[1];
            end
            2'd2: begin
                p_matching_req_o[2] = c_req_i & ~rst_i;
                sel_ready           = p_ready_and_selected_i[2];
            end
            default: begin
                p_matching_req_o = 3'b000;
                sel_ready        = 1'b0;
            end
        endcase
    end

    // Unmapped requests are accepted at once and answered with an error.
    assign c_gnt_o = c_req_i & ~rst_i & (unmapped | sel_ready);

    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    state_q <= c_gnt_o ? RESP : IDLE;
                RESP:    state_q <= c_gnt_o ? RESP : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_q = (state_q == RESP);

    // NOTE: the response payload carries no reset; it is only observed while
    // rsp_valid_q is set, and that flag is reset.
    always_ff @(posedge clk_i) begin
        if (c_gnt_o) begin
            rsp_sel_q  <= region;
            rsp_read_q <= ~c_wen_i;
            rsp_err_q  <= unmapped;
        end
    end

    // Masking with rst_i drops a response whose grant preceded the reset cycle.
    assign c_rvalid_o = rsp_valid_q & ~rst_i;
    assign c_err_o    = c_rvalid_o & rsp_err_q;

    always_comb begin
        c_rdata_o = 32'h0;
        if (c_rvalid_o && rsp_read_q && !rsp_err_q) begin
            case (rsp_sel_q)
                2'd0:    c_rdata_o = p_rdata_i[31:0];
                2'd1:    c_rdata_o = p_rdata_i[63:32];
                2'd2:    c_rdata_o = p_rdata_i[95:64];
                default: c_rdata_o = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || stall_clr_i) begin
            stall_cnt_q <= '0;
        end else if (c_req_i && !c_gnt_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_xbar_controller_port.sv
// Directed self-checking bench for xbar_controller_port: decode, grant,
// response timing, reset discard and stall-counter saturation/clear.
module tb_xbar_controller_port;

    localparam int AW = 16;
    localparam int SW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          c_req_i;
    logic [AW-1:0] c_addr_i;
    logic          c_wen_i;
    logic [31:0]   c_wdata_i;
    logic [3:0]    c_be_i;
    logic          c_gnt_o;
    logic          c_rvalid_o;
    logic [31:0]   c_rdata_o;
    logic          c_err_o;
    logic [2:0]    p_matching_req_o;
    logic [2:0]    p_ready_and_selected_i;
    logic [95:0]   p_rdata_i;
    logic          stall_clr_i;
    logic [SW-1:0] stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    xbar_controller_port #(
        .WORD_ADDR_WIDTH(AW),
        .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .c_req_i               (c_req_i),
        .c_addr_i              (c_addr_i),
        .c_wen_i               (c_wen_i),
        .c_wdata_i             (c_wdata_i),
        .c_be_i                (c_be_i),
        .c_gnt_o               (c_gnt_o),
        .c_rvalid_o            (c_rvalid_o),
        .c_rdata_o             (c_rdata_o),
        .c_err_o               (c_err_o),
        .p_matching_req_o      (p_matching_req_o),
        .p_ready_and_selected_i(p_ready_and_selected_i),
        .p_rdata_i             (p_rdata_i),
        .stall_clr_i           (stall_clr_i),
        .stall_cnt_o           (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i                  = 1'b1;
        c_req_i                = 1'b1;
        c_addr_i               = 16'h4010;
        c_wen_i                = 1'b0;
        c_wdata_i              = 32'hA5A5_0001;
        c_be_i                 = 4'hF;
        p_ready_and_selected_i = 3'b111;
        p_rdata_i              = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
        stall_clr_i            = 1'b0;

        // Reset: grant and matching request forced low, then outputs cleared.
        #2;
        check("rst_gnt", 32'(c_gnt_o), 32'd0);
        check("rst_match", 32'(p_matching_req_o), 32'd0);
        tick();
        tick();
        rst_i = 1'b0; c_req_i = 1'b0; p_ready_and_selected_i = 3'b000;
        #1;
        check("rst_rvalid", 32'(c_rvalid_o), 32'd0);
        check("rst_err", 32'(c_err_o), 32'd0);
        check("rst_rdata", c_rdata_o, 32'd0);
        check("rst_stall", 32'(stall_cnt_o), 32'd0);

        // Mapped read to port 1, granted in the same cycle.
        tick();
        c_req_i = 1'b1; c_addr_i = 16'h4010; c_wen_i = 1'b0; p_ready_and_selected_i = 3'b010;
        #1;
        check("rd_match", 32'(p_matching_req_o), 32'b010);
        check("rd_gnt", 32'(c_gnt_o), 32'd1);
        tick();
        c_req_i = 1'b0; p_ready_and_selected_i = 3'b000;
        #1;
        check("rd_rvalid", 32'(c_rvalid_o), 32'd1);
        check("rd_rdata", c_rdata_o, 32'hDEAD_BEEF);
        check("rd_err", 32'(c_err_o), 32'd0);

        // Stalled write to port 2; grants of other ports must be ignored.
        tick();
        c_req_i = 1'b1; c_addr_i = 16'h8000; c_wen_i = 1'b1; p_ready_and_selected_i = 3'b011;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wr_stall_match%0d", i), 32'(p_matching_req_o), 32'b100);
            check($sformatf("wr_stall_gnt%0d", i), 32'(c_gnt_o), 32'd0);
            tick();
        end
        p_ready_and_selected_i = 3'b100;
        #1;
        check("wr_match", 32'(p_matching_req_o), 32'b100);
        check("wr_gnt", 32'(c_gnt_o), 32'd1);
        tick();
        c_req_i = 1'b0; c_wen_i = 1'b0; p_ready_and_selected_i = 3'b000;
        #1;
        check("wr_rvalid", 32'(c_rvalid_o), 32'd1);
        check("wr_rdata", c_rdata_o, 32'd0);
        check("wr_err", 32'(c_err_o), 32'd0);
        check("wr_stall_cnt", 32'(stall_cnt_o), 32'd3);

        // Unmapped region: immediate accept, error response.
        tick();
        c_req_i = 1'b1; c_addr_i = 16'hC000;
        #1;
        check("um_match", 32'(p_matching_req_o), 32'd0);
        check("um_gnt", 32'(c_gnt_o), 32'd1);
        tick();
        c_req_i = 1'b0;
        #1;
        check("um_rvalid", 32'(c_rvalid_o), 32'd1);
        check("um_err", 32'(c_err_o), 32'd1);
        check("um_rdata", c_rdata_o, 32'd0);

        // Back-to-back reads: port 0 then port 2.
        tick();
        c_req_i = 1'b1; c_addr_i = 16'h0004; p_ready_and_selected_i = 3'b100;
        #1;
        check("bb_match0", 32'(p_matching_req_o), 32'b001);
        check("bb_ignore_bit2", 32'(c_gnt_o), 32'd0);
        tick();
        p_ready_and_selected_i = 3'b101;
        #1;
        check("bb_gnt0", 32'(c_gnt_o), 32'd1);
        tick();
        c_addr_i = 16'h8004; p_ready_and_selected_i = 3'b100;
        #1;
        check("bb_match2", 32'(p_matching_req_o), 32'b100);
        check("bb_gnt2", 32'(c_gnt_o), 32'd1);
        check("bb_rvalid0", 32'(c_rvalid_o), 32'd1);
        check("bb_rdata0", c_rdata_o, 32'h1111_1111);
        tick();
        c_req_i = 1'b0; p_ready_and_selected_i = 3'b000;
        #1;
        check("bb_rvalid2", 32'(c_rvalid_o), 32'd1);
        check("bb_rdata2", c_rdata_o, 32'h3333_3333);
        check("bb_err2", 32'(c_err_o), 32'd0);
        tick();
        #1;
        check("bb_idle", 32'(c_rvalid_o), 32'd0);
        check("bb_stall_cnt", 32'(stall_cnt_o), 32'd4);

        // Reset in the cycle after a grant discards the response.
        c_req_i = 1'b1; c_addr_i = 16'h4010; p_ready_and_selected_i = 3'b010;
        #1;
        check("rm_gnt", 32'(c_gnt_o), 32'd1);
        tick();
        rst_i = 1'b1;
        #1;
        check("rm_rvalid_in_rst", 32'(c_rvalid_o), 32'd0);
        check("rm_gnt_in_rst", 32'(c_gnt_o), 32'd0);
        check("rm_match_in_rst", 32'(p_matching_req_o), 32'd0);
        tick();
        rst_i = 1'b0; c_req_i = 1'b0; p_ready_and_selected_i = 3'b000;
        #1;
        check("rm_rvalid_after", 32'(c_rvalid_o), 32'd0);
        check("rm_stall_cleared", 32'(stall_cnt_o), 32'd0);
        tick();
        #1;
        check("rm_rvalid_later", 32'(c_rvalid_o), 32'd0);

        // Stall counter saturation and clear-over-increment priority.
        c_req_i = 1'b1; c_addr_i = 16'h0000;
        #1;
        check("cnt_gnt", 32'(c_gnt_o), 32'd0);
        repeat (9) tick();
        check("cnt_mid", 32'(stall_cnt_o), 32'd9);
        repeat ((1 << SW) + 5 - 9) tick();
        check("cnt_sat", 32'(stall_cnt_o), 32'hF);
        stall_clr_i = 1'b1;
        tick();
        check("cnt_clr_prio", 32'(stall_cnt_o), 32'd0);
        stall_clr_i = 1'b0;
        tick();
        check("cnt_restart", 32'(stall_cnt_o), 32'd1);
        c_req_i = 1'b0;
        tick();
        check("cnt_hold", 32'(stall_cnt_o), 32'd1);
        check("cnt_no_rvalid", 32'(c_rvalid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xbar_controller_port.md
# xbar_controller_port

Controller-side stage of the crossbar, sitting directly upstream of each peripheral port's arbiter. It takes one controller's request, decodes its word address into one of three peripheral regions, and drives the matching-request line of the selected peripheral port. It then waits for that port's ready-and-selected grant and returns a one-cycle-latency response (read data or error) to the controller. It also keeps a saturating stall counter for performance observation.

## Interface
- `WORD_ADDR_WIDTH`, default 16: controller word-address width. The top 2 bits select the region; the low `WORD_ADDR_WIDTH-2` bits are forwarded by the peripheral port.
- `STALL_CNT_WIDTH`, default 16: width of the stall-cycle counter.

- `clk_i` input 1: clock. Single clock domain.
- `rst_i` input 1: synchronous, active-high reset.
- `c_req_i` input 1: controller request valid.
- `c_addr_i` input WORD_ADDR_WIDTH: controller word address.
- `c_wen_i` input 1: write enable (1 = write).
- `c_wdata_i` input 32: write data. Passed to peripheral ports unchanged, so it is not registered here.
- `c_be_i` input 4: byte enables. Passed through unchanged.
- `c_gnt_o` output 1: request accepted this cycle.
- `c_rvalid_o` output 1: response valid.
- `c_rdata_o` output 32: read data, qualified by `c_rvalid_o`.
- `c_err_o` output 1: response is an error (unmapped address), qualified by `c_rvalid_o`.
- `p_matching_req_o` output 3: one-hot matching request; bit i goes to peripheral port i.
- `p_ready_and_selected_i` input 3: bit i is the grant from peripheral port i.
- `p_rdata_i` input 96: read data from port i on bits [32i+31:32i].
- `stall_clr_i` input 1: synchronous clear of the stall counter.
- `stall_cnt_o` output STALL_CNT_WIDTH: saturating count of cycles with a request pending and not granted.

## Operation
- Region decode uses `c_addr_i[WORD_ADDR_WIDTH-1:WORD_ADDR_WIDTH-2]`:
  - 2'b00 selects port 0.
  - 2'b01 selects port 1.
  - 2'b10 selects port 2.
  - 2'b11 is unmapped.
- **Mapped request:** `p_matching_req_o[i] = c_req_i & (region==i)`, combinational. `c_gnt_o = c_req_i & p_ready_and_selected_i[i]`. Grant bits of non-selected ports are ignored.
- **Unmapped request:** `p_matching_req_o` = 0. `c_gnt_o = c_req_i`, i.e. immediate accept.
- **Controller rule:** the controller holds `c_req_i`, addr, wen, wdata and be stable until `c_gnt_o`. This block never drops a matching request once it is raised.
- **Response register** updates on each cycle with `c_gnt_o`:
  - `rsp_valid_q` ← 1.
  - `rsp_sel_q` ← region.
  - `rsp_read_q` ← `~c_wen_i`.
  - `rsp_err_q` ← unmapped.
  - On a cycle without grant, `rsp_valid_q` ← 0.
- **Response outputs:**
  - `c_rvalid_o = rsp_valid_q`.
  - `c_err_o = rsp_valid_q & rsp_err_q`.
  - `c_rdata_o = p_rdata_i[rsp_sel_q]` when `rsp_valid_q & rsp_read_q & ~rsp_err_q`, otherwise 0.
  - Writes also get an rvalid pulse, with rdata = 0.
- **Stall counter:**
  - Increments each cycle with `c_req_i & ~c_gnt_o`.
  - Saturates at all-ones.
  - `stall_clr_i` sets it to 0 and has priority over increment in the same cycle.
- **Two-state FSM:**
  - IDLE (`rsp_valid_q`=0) → RESP on grant.
  - RESP → RESP on a back-to-back grant.
  - RESP → IDLE otherwise.
- **Reset:**
  - While `rst_i`=1, `c_gnt_o` and `p_matching_req_o` are forced to 0.
  - On the next edge, `c_rvalid_o`, `c_err_o`, `c_rdata_o` and `stall_cnt_o` become 0 and the FSM enters IDLE.
  - Reset asserted in the cycle after a grant discards that response: no rvalid is produced.

## Timing
- Request to matching-req: combinational, same cycle.
- Grant: combinational from `p_ready_and_selected_i`, same cycle.
- Response: `c_rvalid_o` exactly 1 cycle after `c_gnt_o`, for reads, writes and errors alike.
- Peripheral read data is valid in the cycle after the peripheral accepts. `c_rdata_o` is a combinational mux of `p_rdata_i`, selected by the registered `rsp_sel_q`.
- Throughput: one request per cycle. A grant in the same cycle as `c_rvalid_o` is legal, and the responses then appear on consecutive cycles.
- Stall counter: registered, so the value reflects counts up to the previous edge.

## Test plan
- **Mapped read:** addr=0x4010 (region 1, port 1), wen=0, ready_and_selected=3'b010 in the same cycle.
  - Required: `p_matching_req_o`=3'b010 and gnt=1 in cycle T.
  - Required: with `p_rdata_i[63:32]`=0xDEADBEEF in T+1, rvalid=1, rdata=0xDEADBEEF, err=0 in T+1.
- **Stalled write:** addr=0x8000 (port 2), wen=1, grant withheld 3 cycles.
  - Required: matching_req=3'b100 held for 4 cycles, gnt on cycle 4.
  - Required: rvalid=1 with rdata=0 one cycle after gnt.
  - Required: `stall_cnt_o`=3 afterwards.
- **Unmapped:** addr=0xC000.
  - Required: matching_req=0, gnt=1 immediately.
  - Required: next cycle rvalid=1, err=1, rdata=0.
- **Back-to-back:** read port 0, then read port 2, both granted on consecutive cycles.
  - Required: rvalid high 2 consecutive cycles, with rdata taken from port 0 then port 2.
  - Required: grant bit 2 asserted while port 0 is selected is ignored.
- **Reset mid-op:** grant a read, then assert `rst_i` in the next cycle.
  - Required: rvalid stays 0, no response appears afterwards, and gnt/matching_req = 0 during reset.
- **Counter:** hold a request ungranted for 2^STALL_CNT_WIDTH+5 cycles.
  - Required: `stall_cnt_o` saturates at all-ones.
  - Required: `stall_clr_i` together with a stall in the same cycle gives 0.
